// File: rtl/mvm_pp_scheduler_if.sv
// ----------------------------------------------------------------------------
// mvm_pp_scheduler_if
// Handshake and bank-control bundle between the loader, the MAC array and the
// ping-pong bank scheduler.
//   slave  : scheduler side. It receives wr_done, issue_hold, out_valid and
//            out_ready. It drives s_ready, wr_bank, rd_bank, rd_addr,
//            mac_valid_in, mac_first, mac_last, full_cnt and err.
//   master : environment side, with the opposite directions.
// ----------------------------------------------------------------------------
interface mvm_pp_scheduler_if #(
   parameter int unsigned NCOLS = 4
);
   localparam int unsigned AW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

   logic          wr_done;
   logic          issue_hold;
   logic          out_valid;
   logic          out_ready;
   logic          s_ready;
   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] rd_addr;
   logic          mac_valid_in;
   logic          mac_first;
   logic          mac_last;
   logic [1:0]    full_cnt;
   logic          err;

   modport slave (
      input  wr_done, issue_hold, out_valid, out_ready,
      output s_ready, wr_bank, rd_bank, rd_addr, mac_valid_in,
             mac_first, mac_last, full_cnt, err
   );

   modport master (
      output wr_done, issue_hold, out_valid, out_ready,
      input  s_ready, wr_bank, rd_bank, rd_addr, mac_valid_in,
             mac_first, mac_last, full_cnt, err
   );
endinterface

// File: rtl/mvm_pp_scheduler.sv
// ----------------------------------------------------------------------------
// mvm_pp_scheduler
// Ping-pong bank scheduler for the matrix-vector multiplier. It tracks which
// bank the loader fills and which bank the MAC array reads. It issues NCOLS
// read beats for each filled bank. It releases that bank after NROWS results
// have drained downstream.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears all state
//   bus    : mvm_pp_scheduler_if.slave. It carries the loader, issue and drain
//            handshakes and the bank, address and status outputs.
// ----------------------------------------------------------------------------
module mvm_pp_scheduler #(
   parameter int unsigned NROWS = 4,
   parameter int unsigned NCOLS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mvm_pp_scheduler_if.slave     bus
);
   localparam int unsigned AW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int unsigned CW = (NROWS > 1) ? $clog2(NROWS) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NCOLS - 1);
   localparam logic [CW-1:0] LAST_OUT  = CW'(NROWS - 1);

   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_wr_bank;
   logic          r_rd_bank;
   logic [1:0]    r_full_cnt;
   logic [1:0]    w_full_nxt;
   logic [AW-1:0] r_rd_addr;
   logic [CW-1:0] r_out_cnt;
   logic          r_err;

   logic          w_hs;
   logic          w_beat;
   logic          w_release;
   logic          w_wr_acc;

   assign w_hs      = bus.out_valid & bus.out_ready;
   assign w_beat    = (r_state == R_ISSUE) & ~bus.issue_hold;
   assign w_release = (r_state == R_WAIT) & w_hs & (r_out_cnt == LAST_OUT);
   // A release in the same cycle frees a bank, so a write at full_cnt==2 still lands
   assign w_wr_acc  = bus.wr_done & ((r_full_cnt != 2'd2) | w_release);

   always_comb begin
      w_full_nxt = r_full_cnt;
      case ({w_wr_acc, w_release})
         2'b10:   w_full_nxt = r_full_cnt + 2'd1;
         2'b01:   w_full_nxt = r_full_cnt - 2'd1;
         default: w_full_nxt = r_full_cnt;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         R_IDLE:  if (r_full_cnt != 2'd0) w_next_state = R_ISSUE;
         R_ISSUE: if (w_beat && (r_rd_addr == LAST_ADDR)) w_next_state = R_WAIT;
         R_WAIT:  if (w_release)
                     w_next_state = (w_full_nxt != 2'd0) ? R_ISSUE : R_IDLE;
         default: w_next_state = R_IDLE;
      endcase
   end

   // Bank, address, counter and error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_full_cnt <= '0;
         r_rd_addr  <= '0;
         r_out_cnt  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_full_cnt <= w_full_nxt;
         if (w_wr_acc)  r_wr_bank <= ~r_wr_bank;
         if (w_release) r_rd_bank <= ~r_rd_bank;

         if (w_beat)
            r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + AW'(1);
         else if (r_state == R_IDLE)
            r_rd_addr <= '0;

         if ((r_state == R_WAIT) && w_hs)
            r_out_cnt <= w_release ? '0 : r_out_cnt + CW'(1);

         if ((bus.wr_done && (r_full_cnt == 2'd2)) || (w_hs && (r_state != R_WAIT)))
            r_err <= 1'b1;
      end
   end

   // Output logic
   always_comb begin
      bus.s_ready      = (r_full_cnt != 2'd2);
      bus.wr_bank      = r_wr_bank;
      bus.rd_bank      = r_rd_bank;
      bus.rd_addr      = r_rd_addr;
      bus.mac_valid_in = w_beat;
      bus.mac_first    = w_beat & (r_rd_addr == '0);
      bus.mac_last     = w_beat & (r_rd_addr == LAST_ADDR);
      bus.full_cnt     = r_full_cnt;
      bus.err          = r_err;
   end
endmodule

// File: tb/tb_mvm_pp_scheduler.sv
module tb_mvm_pp_scheduler;
   localparam int NR = 4;
   localparam int NC = 4;

   logic clk;
   logic reset;
   mvm_pp_scheduler_if #(.NCOLS(NC)) bus();

   mvm_pp_scheduler #(.NROWS(NR), .NCOLS(NC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Packed view: {s_ready, wr_bank, rd_bank, rd_addr[1:0], mac_valid_in,
   //               mac_first, mac_last, full_cnt[1:0], err}
   function automatic logic [10:0] pk(int sr, int wb, int rb, int addr, int mv,
                                      int mf, int ml, int full, int er);
      logic [1:0] a;
      logic [1:0] f;
      a = addr[1:0];
      f = full[1:0];
      return {sr[0], wb[0], rb[0], a, mv[0], mf[0], ml[0], f, er[0]};
   endfunction

   function automatic logic [10:0] pack_dut();
      return {bus.s_ready, bus.wr_bank, bus.rd_bank, bus.rd_addr, bus.mac_valid_in,
              bus.mac_first, bus.mac_last, bus.full_cnt, bus.err};
   endfunction

   function automatic string fmt(logic [10:0] v);
      return $sformatf("sr=%b wb=%b rb=%b addr=%0d mv=%b mf=%b ml=%b full=%0d err=%b",
                       v[10], v[9], v[8], v[7:6], v[5], v[4], v[3], v[2:1], v[0]);
   endfunction

   task automatic check_vec(input string nm, input logic [10:0] act, input logic [10:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(exp));
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Banks are counted as a number of filled banks. The bank in service is
   // tracked by how many beats it has issued and how many results it has
   // drained.
   int m_full, m_wrb, m_rdb, m_err, m_busy, m_beats, m_drained;

   function automatic void m_reset();
      m_full = 0; m_wrb = 0; m_rdb = 0; m_err = 0;
      m_busy = 0; m_beats = 0; m_drained = 0;
   endfunction

   function automatic logic [10:0] m_out(logic hold);
      int mv, addr;
      mv   = (m_busy != 0 && m_beats < NC && !hold) ? 1 : 0;
      addr = m_beats % NC;
      return pk(m_full != 2, m_wrb, m_rdb, addr, mv,
                mv && addr == 0, mv && addr == NC - 1, m_full, m_err);
   endfunction

   function automatic void m_step(logic wd, logic hold, logic ov, logic ordy);
      bit hs, drain, rel, acc;
      int old_full;
      hs       = ov && ordy;
      drain    = (m_busy != 0) && (m_beats == NC);
      rel      = drain && hs && (m_drained == NR - 1);
      acc      = wd && (m_full < 2 || rel);
      old_full = m_full;
      if (wd && m_full == 2) m_err = 1;
      if (hs && !drain)      m_err = 1;
      m_full = m_full + (acc ? 1 : 0) - (rel ? 1 : 0);
      if (acc) m_wrb ^= 1;
      if (rel) m_rdb ^= 1;
      if (drain && hs) m_drained = rel ? 0 : m_drained + 1;
      if (m_busy != 0 && m_beats < NC && !hold) m_beats++;
      if (rel) begin
         m_beats = 0;
         m_busy  = (m_full > 0) ? 1 : 0;
      end else if (m_busy == 0 && old_full > 0) begin
         m_busy  = 1;
         m_beats = 0;
      end
   endfunction

   // One clock: drive at negedge, sample 2 time units later, step the model at posedge.
   task automatic cyc(input logic wd, input logic hold, input logic ov, input logic ordy,
                      input string nm, input bit use_tbl, input logic [10:0] tbl_exp,
                      output logic [10:0] act);
      @(negedge clk);
      bus.wr_done = wd; bus.issue_hold = hold; bus.out_valid = ov; bus.out_ready = ordy;
      #2;
      act = pack_dut();
      check_vec(nm, act, use_tbl ? tbl_exp : m_out(hold));
      @(posedge clk);
      m_step(wd, hold, ov, ordy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.wr_done = 0; bus.issue_hold = 0; bus.out_valid = 0; bus.out_ready = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_reset();
   endtask

   typedef struct {
      logic wd, hold, ov, ordy;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[14];
   logic [10:0] act;
   int beats;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.wr_done = 0; bus.issue_hold = 0; bus.out_valid = 0; bus.out_ready = 0;
      m_reset();

      // ---- Single bank end-to-end, plus a stray handshake while idle ----
      tbl[0]  = '{0,0,0,0, pk(1,0,0,0,0,0,0,0,0)};
      tbl[1]  = '{1,0,0,0, pk(1,0,0,0,0,0,0,0,0)};
      tbl[2]  = '{0,0,0,0, pk(1,1,0,0,0,0,0,1,0)};
      tbl[3]  = '{0,0,0,0, pk(1,1,0,0,1,1,0,1,0)};
      tbl[4]  = '{0,0,0,0, pk(1,1,0,1,1,0,0,1,0)};
      tbl[5]  = '{0,0,0,0, pk(1,1,0,2,1,0,0,1,0)};
      tbl[6]  = '{0,0,0,0, pk(1,1,0,3,1,0,1,1,0)};
      tbl[7]  = '{0,0,1,1, pk(1,1,0,0,0,0,0,1,0)};
      tbl[8]  = '{0,0,1,1, pk(1,1,0,0,0,0,0,1,0)};
      tbl[9]  = '{0,0,1,1, pk(1,1,0,0,0,0,0,1,0)};
      tbl[10] = '{0,0,1,1, pk(1,1,0,0,0,0,0,1,0)};
      tbl[11] = '{0,0,0,0, pk(1,1,1,0,0,0,0,0,0)};
      tbl[12] = '{0,0,1,1, pk(1,1,1,0,0,0,0,0,0)};
      tbl[13] = '{0,0,0,0, pk(1,1,1,0,0,0,0,0,1)};

      do_reset();
      for (int i = 0; i < 14; i++)
         cyc(tbl[i].wd, tbl[i].hold, tbl[i].ov, tbl[i].ordy,
             $sformatf("tbl[%0d]", i), 1'b1, tbl[i].exp, act);

      // ---- Both banks full, then an illegal third write ----
      do_reset();
      cyc(1,0,0,0, "fill0", 0, '0, act);
      cyc(1,0,0,0, "fill1", 0, '0, act);
      cyc(0,0,0,0, "full2", 0, '0, act);
      chk("full2_cnt", act[2:1], 2);
      chk("full2_sready", act[10], 0);
      chk("full2_wrbank", act[9], 0);
      cyc(1,0,0,0, "third_wr", 0, '0, act);
      cyc(0,0,0,0, "after_third", 0, '0, act);
      chk("third_err", act[0], 1);
      chk("third_full", act[2:1], 2);

      // ---- Write coinciding with release while both banks are full ----
      do_reset();
      cyc(1,0,0,0, "sim_fill0", 0, '0, act);
      cyc(1,0,0,0, "sim_fill1", 0, '0, act);
      for (int i = 0; i < NC; i++) cyc(0,0,0,0, "sim_issue", 0, '0, act);
      for (int i = 0; i < NR - 1; i++) cyc(0,0,1,1, "sim_drain", 0, '0, act);
      chk("sim_pre_full", act[2:1], 2);
      cyc(1,0,1,1, "sim_release", 0, '0, act);
      cyc(0,0,0,0, "sim_after", 0, '0, act);
      chk("sim_full", act[2:1], 2);
      chk("sim_wrbank", act[9], 1);
      chk("sim_rdbank", act[8], 1);
      chk("sim_reissue_mv", act[5], 1);
      chk("sim_reissue_first", act[4], 1);

      // ---- Issue stall on beat 2 ----
      do_reset();
      beats = 0;
      cyc(1,0,0,0, "hold_wr", 0, '0, act);
      cyc(0,0,0,0, "hold_idle", 0, '0, act);
      for (int i = 0; i < 2; i++) begin
         cyc(0,0,0,0, "hold_beat", 0, '0, act);
         beats += int'(act[5]);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0,1,0,0, "hold_stall", 0, '0, act);
         chk("hold_mv_low", act[5], 0);
         chk("hold_addr", act[7:6], 2);
         beats += int'(act[5]);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0,0,0,0, "hold_resume", 0, '0, act);
         beats += int'(act[5]);
      end
      chk("hold_beats", beats, 4);

      // ---- Handshake during issue: error, counter not advanced ----
      do_reset();
      cyc(1,0,0,0, "iss_wr", 0, '0, act);
      cyc(0,0,0,0, "iss_idle", 0, '0, act);
      cyc(0,0,0,0, "iss_b0", 0, '0, act);
      cyc(0,0,1,1, "iss_b1_hs", 0, '0, act);
      cyc(0,0,0,0, "iss_b2", 0, '0, act);
      chk("iss_err", act[0], 1);
      cyc(0,0,0,0, "iss_b3", 0, '0, act);
      for (int i = 0; i < NR - 1; i++) cyc(0,0,1,1, "iss_drain", 0, '0, act);
      cyc(0,0,0,0, "iss_pre_rel", 0, '0, act);
      chk("iss_still_full", act[2:1], 1);
      cyc(0,0,1,1, "iss_rel", 0, '0, act);
      cyc(0,0,0,0, "iss_post", 0, '0, act);
      chk("iss_released", act[2:1], 0);

      // ---- Asynchronous reset while draining ----
      do_reset();
      cyc(1,0,0,0, "ar_wr", 0, '0, act);
      cyc(0,0,0,0, "ar_idle", 0, '0, act);
      for (int i = 0; i < NC; i++) cyc(0,0,0,0, "ar_issue", 0, '0, act);
      for (int i = 0; i < 2; i++) cyc(0,0,1,1, "ar_drain", 0, '0, act);
      @(negedge clk);
      bus.wr_done = 0; bus.issue_hold = 0; bus.out_valid = 0; bus.out_ready = 0;
      #2 reset = 1'b1;
      #1 check_vec("async_reset", pack_dut(), pk(1,0,0,0,0,0,0,0,0));
      m_reset();
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
      cyc(0,0,0,0, "ar_after", 0, '0, act);
      // A fresh bank after reset still needs the full NROWS drain
      cyc(1,0,0,0, "ar_wr2", 0, '0, act);
      for (int i = 0; i < NC + 1; i++) cyc(0,0,0,0, "ar_issue2", 0, '0, act);
      for (int i = 0; i < NR; i++) cyc(0,0,1,1, "ar_drain2", 0, '0, act);
      cyc(0,0,0,0, "ar_done2", 0, '0, act);

      // ---- Randomized runs against the reference model ----
      for (int run = 0; run < 4; run++) begin
         do_reset();
         for (int n = 0; n < 400; n++) begin
            logic wd, hold, ov, ordy;
            hold = ($urandom_range(0, 3) == 0);
            if (run % 2 == 0) begin
               wd   = (m_full < 2) && ($urandom_range(0, 2) == 0);
               ov   = (m_busy != 0 && m_beats == NC) && ($urandom_range(0, 1) == 1);
               ordy = ov && ($urandom_range(0, 3) != 0);
            end else begin
               wd   = ($urandom_range(0, 3) == 0);
               ov   = ($urandom_range(0, 1) == 1);
               ordy = ($urandom_range(0, 1) == 1);
            end
            cyc(wd, hold, ov, ordy, $sformatf("rand%0d[%0d]", run, n), 0, '0, act);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
